// File: rtl/dma_read_data_to_tcp.sv
// Streams a host buffer to a TCP session in packets of at most PKT_LEN bytes.
// Metadata is accepted by the TCP stack before the matching DMA read is issued.
module dma_read_data_to_tcp #(
  parameter int PKT_LEN   = 1024,
  parameter int RETRY_GAP = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  session_id,
  input  logic [63:0]  base_addr,
  input  logic [31:0]  total_len,
  output logic         m_axis_tx_meta_valid,
  input  logic         m_axis_tx_meta_ready,
  output logic [31:0]  m_axis_tx_meta_data,
  input  logic         s_axis_tx_status_valid,
  output logic         s_axis_tx_status_ready,
  input  logic [63:0]  s_axis_tx_status_data,
  output logic         m_axis_dma_read_cmd_valid,
  input  logic         m_axis_dma_read_cmd_ready,
  output logic [63:0]  m_axis_dma_read_cmd_address,
  output logic [31:0]  m_axis_dma_read_cmd_length,
  input  logic         s_axis_dma_read_data_valid,
  output logic         s_axis_dma_read_data_ready,
  input  logic [511:0] s_axis_dma_read_data_data,
  input  logic [63:0]  s_axis_dma_read_data_keep,
  input  logic         s_axis_dma_read_data_last,
  output logic         m_axis_tx_data_valid,
  input  logic         m_axis_tx_data_ready,
  output logic [511:0] m_axis_tx_data_data,
  output logic [63:0]  m_axis_tx_data_keep,
  output logic         m_axis_tx_data_last,
  output logic         busy,
  output logic         done,
  output logic [31:0]  pkt_cnt,
  output logic [31:0]  err_cnt
);

  typedef enum logic [2:0] {IDLE, META, STATUS, RETRY, CMD, DATA, DONE} state_t;

  localparam logic [15:0] PKT_LEN_W = 16'(PKT_LEN);
  localparam logic [15:0] GAP_W     = 16'(RETRY_GAP);

  state_t      state_r;
  logic [15:0] session_r;
  logic [63:0] addr_r;
  logic [31:0] remaining_r;
  logic [10:0] beat_r;
  logic [15:0] gap_r;
  logic        meta_valid_r;
  logic        status_ready_r;
  logic        cmd_valid_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] pkt_cnt_r;
  logic [31:0] err_cnt_r;

  logic [15:0] len_s;
  logic [10:0] beats_s;
  logic        last_beat_s;
  logic [63:0] tail_keep_s;
  logic        data_hs_s;
  logic [31:0] rem_next_s;
  logic        unused_s;

  // Packet geometry derives from remaining_r, which only moves at packet end.
  always_comb begin
    len_s       = (remaining_r < {16'd0, PKT_LEN_W}) ? remaining_r[15:0] : PKT_LEN_W;
    beats_s     = 11'((17'(len_s) + 17'd63) >> 6);
    last_beat_s = (beat_r == (beats_s - 11'd1));
    if (len_s[5:0] == 6'd0) begin
      tail_keep_s = {64{1'b1}};
    end else begin
      tail_keep_s = (64'd1 << len_s[5:0]) - 64'd1;
    end
    data_hs_s  = (state_r == DATA) && s_axis_dma_read_data_valid && m_axis_tx_data_ready;
    rem_next_s = remaining_r - {16'd0, len_s};
  end

  assign unused_s = ^{s_axis_tx_status_data[61:0], s_axis_dma_read_data_keep,
                      s_axis_dma_read_data_last};

  assign m_axis_tx_meta_valid        = meta_valid_r;
  assign m_axis_tx_meta_data         = {len_s, session_r};
  assign s_axis_tx_status_ready      = status_ready_r;
  assign m_axis_dma_read_cmd_valid   = cmd_valid_r;
  assign m_axis_dma_read_cmd_address = addr_r;
  assign m_axis_dma_read_cmd_length  = {16'd0, len_s};
  // DMA beats pass straight through; framing is regenerated from len_s.
  assign m_axis_tx_data_valid        = (state_r == DATA) && s_axis_dma_read_data_valid;
  assign s_axis_dma_read_data_ready  = (state_r == DATA) && m_axis_tx_data_ready;
  assign m_axis_tx_data_data         = s_axis_dma_read_data_data;
  assign m_axis_tx_data_keep         = last_beat_s ? tail_keep_s : {64{1'b1}};
  assign m_axis_tx_data_last         = last_beat_s;
  assign busy                        = busy_r;
  assign done                        = done_r;
  assign pkt_cnt                     = pkt_cnt_r;
  assign err_cnt                     = err_cnt_r;

  // Transfer sequencer with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      session_r      <= 16'd0;
      addr_r         <= 64'd0;
      remaining_r    <= 32'd0;
      beat_r         <= 11'd0;
      gap_r          <= 16'd0;
      meta_valid_r   <= 1'b0;
      status_ready_r <= 1'b0;
      cmd_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pkt_cnt_r      <= 32'd0;
      err_cnt_r      <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (total_len != 32'd0) begin
              session_r    <= session_id;
              addr_r       <= base_addr;
              remaining_r  <= total_len;
              pkt_cnt_r    <= 32'd0;
              err_cnt_r    <= 32'd0;
              busy_r       <= 1'b1;
              meta_valid_r <= 1'b1;
              state_r      <= META;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        META: begin
          if (m_axis_tx_meta_ready) begin
            meta_valid_r   <= 1'b0;
            status_ready_r <= 1'b1;
            state_r        <= STATUS;
          end
        end
        STATUS: begin
          if (s_axis_tx_status_valid) begin
            status_ready_r <= 1'b0;
            if (s_axis_tx_status_data[63:62] == 2'b00) begin
              cmd_valid_r <= 1'b1;
              state_r     <= CMD;
            end else begin
              err_cnt_r <= err_cnt_r + 32'd1;
              gap_r     <= GAP_W;
              state_r   <= RETRY;
            end
          end
        end
        RETRY: begin
          if (gap_r <= 16'd1) begin
            meta_valid_r <= 1'b1;
            state_r      <= META;
          end else begin
            gap_r <= gap_r - 16'd1;
          end
        end
        CMD: begin
          if (m_axis_dma_read_cmd_ready) begin
            cmd_valid_r <= 1'b0;
            beat_r      <= 11'd0;
            state_r     <= DATA;
          end
        end
        DATA: begin
          if (data_hs_s) begin
            if (last_beat_s) begin
              addr_r      <= addr_r + {48'd0, len_s};
              remaining_r <= rem_next_s;
              pkt_cnt_r   <= pkt_cnt_r + 32'd1;
              if (rem_next_s != 32'd0) begin
                meta_valid_r <= 1'b1;
                state_r      <= META;
              end else begin
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= DONE;
              end
            end else begin
              beat_r <= beat_r + 11'd1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_data_to_tcp.sv
// Randomized bench: reactive stream agents record every handshake and a
// packetization model built from the transfer rules supplies the expectations.
module tb_dma_read_data_to_tcp;
  localparam int PKT = 1024;
  localparam int GAP = 16;

  typedef struct packed {logic [511:0] data; logic [63:0] keep; logic last;} beat_t;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0]  session_id = 16'd0;
  logic [63:0]  base_addr = 64'd0;
  logic [31:0]  total_len = 32'd0;
  logic         m_axis_tx_meta_valid, m_axis_tx_meta_ready = 1'b0;
  logic [31:0]  m_axis_tx_meta_data;
  logic         s_axis_tx_status_valid = 1'b0, s_axis_tx_status_ready;
  logic [63:0]  s_axis_tx_status_data = 64'd0;
  logic         m_axis_dma_read_cmd_valid, m_axis_dma_read_cmd_ready = 1'b0;
  logic [63:0]  m_axis_dma_read_cmd_address;
  logic [31:0]  m_axis_dma_read_cmd_length;
  logic         s_axis_dma_read_data_valid = 1'b0, s_axis_dma_read_data_ready;
  logic [511:0] s_axis_dma_read_data_data = 512'd0;
  logic [63:0]  s_axis_dma_read_data_keep = 64'd0;
  logic         s_axis_dma_read_data_last = 1'b0;
  logic         m_axis_tx_data_valid, m_axis_tx_data_ready = 1'b0;
  logic [511:0] m_axis_tx_data_data;
  logic [63:0]  m_axis_tx_data_keep;
  logic         m_axis_tx_data_last;
  logic         busy, done;
  logic [31:0]  pkt_cnt, err_cnt;

  int n_chk = 0, n_fail = 0;
  longint cyc = 0;
  int meta_mode = 0, cmd_mode = 0, tx_mode = 0, src_mode = 0;
  bit mirror_en = 1'b0, tog = 1'b0, st_taken = 1'b0, dma_taken = 1'b0;
  int st_pend = 0, beats_left = 0;
  logic [1:0]   err_plan[$];
  logic [31:0]  meta_q[$];
  longint       meta_t[$], stat_t[$];
  logic [95:0]  cmd_q[$];
  logic [511:0] dma_q[$];
  beat_t        tx_q[$];

  dma_read_data_to_tcp #(.PKT_LEN(PKT), .RETRY_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .session_id(session_id),
    .base_addr(base_addr), .total_len(total_len),
    .m_axis_tx_meta_valid(m_axis_tx_meta_valid), .m_axis_tx_meta_ready(m_axis_tx_meta_ready),
    .m_axis_tx_meta_data(m_axis_tx_meta_data),
    .s_axis_tx_status_valid(s_axis_tx_status_valid), .s_axis_tx_status_ready(s_axis_tx_status_ready),
    .s_axis_tx_status_data(s_axis_tx_status_data),
    .m_axis_dma_read_cmd_valid(m_axis_dma_read_cmd_valid),
    .m_axis_dma_read_cmd_ready(m_axis_dma_read_cmd_ready),
    .m_axis_dma_read_cmd_address(m_axis_dma_read_cmd_address),
    .m_axis_dma_read_cmd_length(m_axis_dma_read_cmd_length),
    .s_axis_dma_read_data_valid(s_axis_dma_read_data_valid),
    .s_axis_dma_read_data_ready(s_axis_dma_read_data_ready),
    .s_axis_dma_read_data_data(s_axis_dma_read_data_data),
    .s_axis_dma_read_data_keep(s_axis_dma_read_data_keep),
    .s_axis_dma_read_data_last(s_axis_dma_read_data_last),
    .m_axis_tx_data_valid(m_axis_tx_data_valid), .m_axis_tx_data_ready(m_axis_tx_data_ready),
    .m_axis_tx_data_data(m_axis_tx_data_data), .m_axis_tx_data_keep(m_axis_tx_data_keep),
    .m_axis_tx_data_last(m_axis_tx_data_last),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Stream agents: drive on the falling edge, log handshakes due at the next rising edge.
  initial begin : env
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        st_pend = 0; beats_left = 0; st_taken = 1'b0; dma_taken = 1'b0;
        s_axis_tx_status_valid = 1'b0; s_axis_dma_read_data_valid = 1'b0;
        m_axis_tx_meta_ready = 1'b0; m_axis_dma_read_cmd_ready = 1'b0;
        m_axis_tx_data_ready = 1'b0;
      end else begin
        tog = ~tog;
        m_axis_tx_meta_ready      = pick(meta_mode);
        m_axis_dma_read_cmd_ready = pick(cmd_mode);
        m_axis_tx_data_ready      = (tx_mode == 2) ? tog : pick(tx_mode);
        if (st_taken) begin s_axis_tx_status_valid = 1'b0; st_taken = 1'b0; end
        if (!s_axis_tx_status_valid && st_pend > 0 && pick(src_mode)) begin
          if (err_plan.size() > 0) e = err_plan.pop_front();
          else e = 2'd0;
          s_axis_tx_status_data  = {e, 30'($urandom), $urandom};
          s_axis_tx_status_valid = 1'b1;
          st_pend--;
        end
        if (dma_taken) begin s_axis_dma_read_data_valid = 1'b0; dma_taken = 1'b0; end
        if (!s_axis_dma_read_data_valid && beats_left > 0 && pick(src_mode)) begin
          for (int k = 0; k < 16; k++) s_axis_dma_read_data_data[k*32 +: 32] = $urandom;
          s_axis_dma_read_data_keep  = {$urandom, $urandom};
          s_axis_dma_read_data_last  = 1'($urandom_range(0, 1));
          s_axis_dma_read_data_valid = 1'b1;
          beats_left--;
        end
        #1;
        if (m_axis_tx_meta_valid && m_axis_tx_meta_ready) begin
          meta_q.push_back(m_axis_tx_meta_data); meta_t.push_back(cyc); st_pend++;
        end
        if (s_axis_tx_status_valid && s_axis_tx_status_ready) begin
          stat_t.push_back(cyc); st_taken = 1'b1;
        end
        if (m_axis_dma_read_cmd_valid && m_axis_dma_read_cmd_ready) begin
          cmd_q.push_back({m_axis_dma_read_cmd_address, m_axis_dma_read_cmd_length});
          beats_left += int'((m_axis_dma_read_cmd_length + 32'd63) / 32'd64);
        end
        if (s_axis_dma_read_data_valid && s_axis_dma_read_data_ready) begin
          dma_q.push_back(s_axis_dma_read_data_data); dma_taken = 1'b1;
        end
        if (m_axis_tx_data_valid && m_axis_tx_data_ready)
          tx_q.push_back({m_axis_tx_data_data, m_axis_tx_data_keep, m_axis_tx_data_last});
        if (mirror_en && m_axis_tx_data_valid)
          chk("dma_ready_mirror", s_axis_dma_read_data_ready, m_axis_tx_data_ready);
      end
    end
  end

  task automatic clear_q();
    meta_q.delete(); meta_t.delete(); stat_t.delete(); cmd_q.delete();
    dma_q.delete(); tx_q.delete(); err_plan.delete();
  endtask

  task automatic pulse_start(input logic [63:0] b, input logic [31:0] t, input logic [15:0] s);
    @(negedge clk);
    base_addr = b; total_len = t; session_id = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_xfer(input logic [63:0] base, input logic [31:0] total, input logic [15:0] sess,
                         input logic [1:0] plan[$], input int inject_at);
    logic [31:0] exp_meta[$];
    logic [95:0] exp_cmd[$];
    beat_t       exp_beat[$];
    beat_t       b;
    longint      rem, off;
    int          len, nb, si, nerr, npk;
    logic [1:0]  e;
    bit          seen;
    rem = longint'(total); off = 0; si = 0; nerr = 0; npk = 0; seen = 1'b0;
    while (rem > 0) begin
      len = (rem < PKT) ? int'(rem) : PKT;
      do begin
        exp_meta.push_back({16'(len), sess});
        e = (si < plan.size()) ? plan[si] : 2'd0;
        si++;
        if (e != 2'd0) nerr++;
      end while (e != 2'd0);
      exp_cmd.push_back({base + 64'(off), 32'(len)});
      nb = (len + 63) / 64;
      for (int k = 0; k < nb; k++) begin
        b.data = '0; b.keep = '0; b.last = (k == nb - 1);
        for (int j = 0; j < 64; j++)
          if (k < nb - 1 || j < len - 64 * (nb - 1)) b.keep[j] = 1'b1;
        exp_beat.push_back(b);
      end
      off += len; rem -= len; npk++;
    end
    clear_q();
    err_plan = plan;
    pulse_start(base, total, sess);
    chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 20000 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        start = (i == inject_at);
        if (i == inject_at) begin session_id = ~sess; base_addr = ~base; total_len = 32'h3; end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("pkt_cnt", pkt_cnt, 32'(npk));
    chk("err_cnt", err_cnt, 32'(nerr));
    chk("meta_count", meta_q.size(), exp_meta.size());
    for (int i = 0; i < meta_q.size() && i < exp_meta.size(); i++) chk("meta_data", meta_q[i], exp_meta[i]);
    chk("cmd_count", cmd_q.size(), exp_cmd.size());
    for (int i = 0; i < cmd_q.size() && i < exp_cmd.size(); i++) chk("cmd_addr_len", cmd_q[i], exp_cmd[i]);
    chk("beat_count", tx_q.size(), exp_beat.size());
    chk("dma_beat_count", dma_q.size(), exp_beat.size());
    for (int i = 0; i < tx_q.size() && i < exp_beat.size() && i < dma_q.size(); i++) begin
      chk("beat_data", tx_q[i].data, dma_q[i]);
      chk("beat_keep", tx_q[i].keep, exp_beat[i].keep);
      chk("beat_last", tx_q[i].last, exp_beat[i].last);
    end
  endtask

  initial begin : main
    logic [1:0] plan[$];
    bit reached;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("rst_meta_valid", m_axis_tx_meta_valid, 1'b0);
    chk("rst_status_ready", s_axis_tx_status_ready, 1'b0);
    chk("rst_cmd_valid", m_axis_dma_read_cmd_valid, 1'b0);
    chk("rst_dma_ready", s_axis_dma_read_data_ready, 1'b0);
    rst = 1'b0;

    // two full packets, everything always ready
    plan.delete();
    do_xfer(64'h0000_1000_0000_0000, 32'h800, 16'h0002, plan, -1);
    chk("t1_meta0", (meta_q.size() > 0) ? meta_q[0] : 32'h0, 32'h0400_0002);
    chk("t1_cmd1", (cmd_q.size() > 1) ? cmd_q[1] : 96'h0, {64'h0000_1000_0000_0400, 32'h400});

    // short packet with a partial final beat
    do_xfer(64'h0000_0000_2000_0040, 32'h4A, 16'h0011, plan, -1);
    chk("t2_keep", (tx_q.size() > 1) ? tx_q[1].keep : 64'h0, 64'h3FF);
    chk("t2_last", (tx_q.size() > 1) ? tx_q[1].last : 1'b0, 1'b1);

    // one rejected status then acceptance
    plan.push_back(2'd1); plan.push_back(2'd0);
    do_xfer(64'h0000_0000_0300_0000, 32'h100, 16'h0123, plan, -1);
    chk("t3_retry_gap", (meta_t.size() > 1 && stat_t.size() > 0) ? ((meta_t[1] - stat_t[0]) > GAP) : 1'b0, 1'b1);
    plan.delete();

    // alternating tx backpressure with gappy DMA source
    tx_mode = 2; src_mode = 1; mirror_en = 1'b1;
    do_xfer(64'h0000_0000_0400_0000, 32'h800, 16'h0BEE, plan, -1);
    tx_mode = 0; src_mode = 0; mirror_en = 1'b0;

    // start while busy must be ignored
    do_xfer(64'h0000_0000_0500_0000, 32'hC00, 16'h0CAB, plan, 30);

    // reset in the middle of the data phase
    clear_q();
    pulse_start(64'h0000_0000_0600_0000, 32'h800, 16'h0D00);
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (tx_q.size() >= 5) reached = 1'b1;
      else @(negedge clk);
    end
    chk("t6_reach_beat5", reached, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tx_valid", m_axis_tx_data_valid, 1'b0);
    chk("t6_rst_dma_ready", s_axis_dma_read_data_ready, 1'b0);
    chk("t6_rst_meta_valid", m_axis_tx_meta_valid, 1'b0);
    chk("t6_rst_cmd_valid", m_axis_dma_read_cmd_valid, 1'b0);
    chk("t6_rst_status_ready", s_axis_tx_status_ready, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pkt_cnt", pkt_cnt, 32'd0);
    repeat (2) @(negedge clk);
    clear_q();
    rst = 1'b0;
    do_xfer(64'h0000_ABCD_0000_1000, 32'h150, 16'h7777, plan, -1);

    // zero length
    clear_q();
    pulse_start(64'h0000_0000_0700_0000, 32'h0, 16'h0E0E);
    chk("t7_done", done, 1'b1);
    chk("t7_busy", busy, 1'b0);
    @(negedge clk);
    chk("t7_done_pulse", done, 1'b0);
    repeat (10) @(negedge clk);
    chk("t7_no_meta", meta_q.size(), 0);
    chk("t7_no_cmd", cmd_q.size(), 0);

    // randomized transfers with random backpressure and status errors
    for (int r = 0; r < 4; r++) begin
      meta_mode = 1; cmd_mode = 1; tx_mode = 1; src_mode = 1;
      plan.delete();
      for (int p = $urandom_range(0, 3); p > 0; p--) plan.push_back(2'($urandom_range(0, 3)));
      do_xfer({$urandom, $urandom}, 32'($urandom_range(1, 3000)), 16'($urandom), plan, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
